// File: rtl/fetch_sequencer.sv
// fetch_sequencer: fetch-stage controller. It owns the architectural PC, issues one
// instruction-memory read at a time and hands {pc, instr} to decode through a
// registered valid/ready stage. Redirects from execute replace the PC. A response
// that belongs to a fetch overtaken by a redirect is discarded.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   redirect_valid, redirect_target  PC redirect from execute (target[1:0] ignored)
//   imem_req_valid/ready/addr        request to instruction memory (addr = pc)
//   imem_rsp_valid/data              read response from instruction memory
//   dec_valid/ready, dec_pc/instr    registered output stage to decode
//   pc                               current next-fetch PC
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_instr,
  output logic [31:0] pc
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic              kill_q, kill_d;
  logic              req_valid_q, req_valid_d;
  logic              dec_valid_q, dec_valid_d;
  logic [XLEN-1:0]   dec_pc_q, dec_pc_d;
  logic [XLEN-1:0]   dec_instr_q, dec_instr_d;
  logic [XLEN-1:0]   target_c;

  // Redirect targets are word aligned; low two bits are dropped.
  assign target_c = redirect_target & ~XLEN'(3);

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_pc_d  = fetch_pc_q;
    kill_d      = kill_q;
    dec_valid_d = dec_valid_q;
    dec_pc_d    = dec_pc_q;
    dec_instr_d = dec_instr_q;

    case (state_q)
      IDLE: begin
        state_d = REQ;
        if (redirect_valid) pc_d = target_c;
      end
      REQ: begin
        if (imem_req_ready) begin
          fetch_pc_d = pc_q;
          state_d    = WAIT;
          // The fetch just issued is already stale; mark its response for discard.
          if (redirect_valid) begin
            kill_d = 1'b1;
            pc_d   = target_c;
          end
        end else if (redirect_valid) begin
          pc_d = target_c;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          if (kill_q || redirect_valid) begin
            kill_d  = 1'b0;
            state_d = REQ;
            if (redirect_valid) pc_d = target_c;
          end else begin
            dec_valid_d = 1'b1;
            dec_pc_d    = fetch_pc_q;
            dec_instr_d = imem_rsp_data;
            pc_d        = fetch_pc_q + XLEN'(PC_STEP);
            state_d     = HOLD;
          end
        end else if (redirect_valid) begin
          kill_d = 1'b1;
          pc_d   = target_c;
        end
      end
      HOLD: begin
        // A redirect squashes the held instruction even if decode is ready.
        if (redirect_valid) begin
          dec_valid_d = 1'b0;
          pc_d        = target_c;
          state_d     = REQ;
        end else if (dec_ready) begin
          dec_valid_d = 1'b0;
          state_d     = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    req_valid_d = (state_d == REQ);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_VECTOR;
      fetch_pc_q  <= '0;
      kill_q      <= 1'b0;
      req_valid_q <= 1'b0;
      dec_valid_q <= 1'b0;
      dec_pc_q    <= '0;
      dec_instr_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_pc_q  <= fetch_pc_d;
      kill_q      <= kill_d;
      req_valid_q <= req_valid_d;
      dec_valid_q <= dec_valid_d;
      dec_pc_q    <= dec_pc_d;
      dec_instr_q <= dec_instr_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign dec_valid      = dec_valid_q;
  assign dec_pc         = dec_pc_q;
  assign dec_instr      = dec_instr_q;

endmodule
